// File: rtl/add_vec_pkg.sv
// Shared types and lane-limit helpers for the streaming vector adder.
package add_vec_pkg;

  typedef enum logic [1:0] {
    MODE_ADD  = 2'b00,
    MODE_SUB  = 2'b01,
    MODE_ACC  = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Largest positive two's-complement value of a w-bit lane, zero-extended to 64 bits.
  function automatic logic [63:0] lane_max(input int unsigned w);
    lane_max = (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative w-bit two's-complement value (bit pattern 100..0), zero-extended.
  function automatic logic [63:0] lane_min(input int unsigned w);
    lane_min = 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sat_addsub_lane.sv
// One signed lane: add or subtract on a WIDTH+1 bit datapath with overflow
// detection and optional clamping.
module sat_addsub_lane
  import add_vec_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter bit SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(lane_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(lane_min(WIDTH));

  logic [WIDTH:0] w_a_ext;
  logic [WIDTH:0] w_b_ext;
  logic [WIDTH:0] w_res;

  assign w_a_ext = {a[WIDTH-1], a};
  assign w_b_ext = {b[WIDTH-1], b};
  assign w_res   = sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
  assign ovf     = w_res[WIDTH] ^ w_res[WIDTH-1];

  // The extended top bit carries the true sign, so it picks the clamp direction.
  always_comb begin
    sum = w_res[WIDTH-1:0];
    if (SATURATE && ovf) begin
      sum = w_res[WIDTH] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/add_vec_stream.sv
// Streaming per-lane add/sub/accumulate with valid/ready on both sides and a
// single registered output stage.
//
//   state | meaning
//   IDLE  | no accumulation open; ADD/SUB and single-beat ACC emit directly
//   ACCUM | partial sums held in r_acc; every beat accumulates until last
module add_vec_stream
  import add_vec_pkg::*;
#(
  parameter int DIM      = 4,
  parameter int WIDTH    = 16,
  parameter int FRAC     = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIM*WIDTH-1:0] a_vec,
  input  logic [DIM*WIDTH-1:0] b_vec,
  input  logic [1:0]           mode,
  input  logic                 last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DIM*WIDTH-1:0] out_vec,
  output logic [DIM-1:0]       out_ovf
);

  generate
    if (FRAC < 0 || FRAC > WIDTH) begin : g_bad_frac
      $error("FRAC must lie within 0..WIDTH");
    end
  endgenerate

  state_e               r_state;
  state_e               w_state_nxt;
  logic [DIM*WIDTH-1:0] r_acc;
  logic [DIM*WIDTH-1:0] r_out_vec;
  logic [DIM-1:0]       r_out_ovf;
  logic [DIM-1:0]       r_sticky;
  logic                 r_out_valid;

  logic                 w_accept;
  logic                 w_acc_path;
  logic                 w_sub;
  logic                 w_emit;
  logic                 w_acc_upd;
  logic [DIM*WIDTH-1:0] w_op_a;
  logic [DIM*WIDTH-1:0] w_op_b;
  logic [DIM*WIDTH-1:0] w_sum;
  logic [DIM-1:0]       w_ovf;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = r_out_valid;
  assign out_vec   = r_out_vec;
  assign out_ovf   = r_out_ovf;

  // Accumulate path reuses the lane adders: acc (or 0 when opening) + a_vec.
  assign w_acc_path = (r_state == ACCUM) || (mode == MODE_ACC);
  assign w_sub      = !w_acc_path && (mode == MODE_SUB);
  assign w_op_a     = !w_acc_path ? a_vec : ((r_state == ACCUM) ? r_acc : '0);
  assign w_op_b     = w_acc_path ? a_vec : b_vec;

  generate
    for (genvar i = 0; i < DIM; i++) begin : g_lane
      sat_addsub_lane #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
      ) u_lane (
        .a   (w_op_a[i*WIDTH +: WIDTH]),
        .b   (w_op_b[i*WIDTH +: WIDTH]),
        .sub (w_sub),
        .sum (w_sum[i*WIDTH +: WIDTH]),
        .ovf (w_ovf[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_acc_upd   = 1'b0;
    if (w_accept) begin
      case (r_state)
        IDLE: begin
          if (mode == MODE_ACC) begin
            if (last) begin
              w_emit = 1'b1;
            end else begin
              w_acc_upd   = 1'b1;
              w_state_nxt = ACCUM;
            end
          end else begin
            w_emit = 1'b1;
          end
        end
        ACCUM: begin
          if (last) begin
            w_emit      = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_acc_upd = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_vec   <= '0;
      r_out_ovf   <= '0;
      r_acc       <= '0;
      r_sticky    <= '0;
    end else if (w_emit) begin
      r_out_valid <= 1'b1;
      r_out_vec   <= w_sum;
      r_out_ovf   <= w_ovf | r_sticky;
      r_acc       <= '0;
      r_sticky    <= '0;
    end else begin
      if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_acc_upd) begin
        r_acc    <= w_sum;
        r_sticky <= r_sticky | w_ovf;
      end
    end
  end

endmodule

// File: tb/tb_add_vec_stream.sv
// Scoreboard bench: saturating and wrapping instances share stimulus; monitors
// pop expected results whenever an output transfers.
module tb_add_vec_stream;
  import add_vec_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        last = 1'b0;
  logic        out_ready = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic [63:0] a_vec = '0;
  logic [63:0] b_vec = '0;

  logic        in_ready_s, out_valid_s, in_ready_w, out_valid_w;
  logic [63:0] out_vec_s, out_vec_w;
  logic [3:0]  out_ovf_s, out_ovf_w;

  typedef struct packed {
    logic [63:0] vec;
    logic [3:0]  ovf;
  } res_t;

  res_t q_s[$];
  res_t q_w[$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  add_vec_stream #(.DIM(4), .WIDTH(16), .FRAC(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .a_vec(a_vec), .b_vec(b_vec), .mode(mode), .last(last),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_vec(out_vec_s), .out_ovf(out_ovf_s)
  );

  add_vec_stream #(.DIM(4), .WIDTH(16), .FRAC(8), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
    .a_vec(a_vec), .b_vec(b_vec), .mode(mode), .last(last),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_vec(out_vec_w), .out_ovf(out_ovf_w)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid_s && out_ready) begin
      if (q_s.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sat_unexpected_output: got %h expected no output", out_vec_s);
      end else begin
        res_t e;
        e = q_s.pop_front();
        chk("sat_vec", out_vec_s, e.vec);
        chk("sat_ovf", {60'd0, out_ovf_s}, {60'd0, e.ovf});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_w && out_ready) begin
      if (q_w.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wrap_unexpected_output: got %h expected no output", out_vec_w);
      end else begin
        res_t e;
        e = q_w.pop_front();
        chk("wrap_vec", out_vec_w, e.vec);
        chk("wrap_ovf", {60'd0, out_ovf_w}, {60'd0, e.ovf});
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b,
                      input logic l, input bit exp_out, input logic [63:0] es,
                      input logic [63:0] ew, input logic [3:0] eo);
    bit ok;
    int n;
    mode = m; a_vec = a; b_vec = b; last = l; in_valid = 1'b1;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = in_ready_s;
      if (ok && exp_out) begin
        q_s.push_back(res_t'{vec: es, ovf: eo});
        q_w.push_back(res_t'{vec: ew, ovf: eo});
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got no accept expected accept within 50 cycles");
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    chk("rst_out_valid", {63'd0, out_valid_s}, 64'd0);
    chk("rst_out_vec", out_vec_s, 64'd0);
    chk("rst_out_ovf", {60'd0, out_ovf_s}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready_s}, 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(1);

    // ADD, one-cycle latency
    chk("pre_add_valid", {63'd0, out_valid_s}, 64'd0);
    send(MODE_ADD, 64'h0000_0010_FFFF_0100, 64'h0000_0020_0001_0200, 1'b0, 1'b1,
         64'h0000_0030_0000_0300, 64'h0000_0030_0000_0300, 4'b0000);
    chk("add_latency_valid", {63'd0, out_valid_s}, 64'd1);

    // Positive and negative overflow
    send(MODE_ADD, 64'h8000_7F00_0001_7F00, 64'hFFFF_0100_0001_0200, 1'b0, 1'b1,
         64'h8000_7FFF_0002_7FFF, 64'h7FFF_8000_0002_8100, 4'b1101);
    // SUB underflow on lane 0
    send(MODE_SUB, 64'h0300_0300_0300_8000, 64'h0100_0100_0100_0100, 1'b0, 1'b1,
         64'h0200_0200_0200_8000, 64'h0200_0200_0200_7F00, 4'b0001);
    // Reserved mode acts as ADD
    send(MODE_RSVD, 64'h0001_0001_0001_0001, 64'h0002_0002_0002_0002, 1'b0, 1'b1,
         64'h0003_0003_0003_0003, 64'h0003_0003_0003_0003, 4'b0000);

    // Three-beat accumulation; middle beat carries ADD mode but must accumulate
    send(MODE_ACC, 64'h0100_0100_0100_0100, 64'h1234_1234_1234_1234, 1'b0, 1'b0, '0, '0, '0);
    send(MODE_ADD, 64'h0100_0100_0100_0100, 64'h1234_1234_1234_1234, 1'b0, 1'b0, '0, '0, '0);
    send(MODE_ACC, 64'h0100_0100_0100_0100, 64'h1234_1234_1234_1234, 1'b1, 1'b1,
         64'h0300_0300_0300_0300, 64'h0300_0300_0300_0300, 4'b0000);
    chk("acc_last_valid", {63'd0, out_valid_s}, 64'd1);
    send(MODE_ADD, 64'h0005_0005_0005_0005, 64'h0003_0003_0003_0003, 1'b0, 1'b1,
         64'h0008_0008_0008_0008, 64'h0008_0008_0008_0008, 4'b0000);

    // Accumulation with sticky overflow on lane 0
    send(MODE_ACC, 64'h0001_0001_0001_7000, '0, 1'b0, 1'b0, '0, '0, '0);
    send(MODE_ACC, 64'h0001_0001_0001_7000, '0, 1'b0, 1'b0, '0, '0, '0);
    send(MODE_ACC, 64'h0001_0001_0001_7000, '0, 1'b1, 1'b1,
         64'h0003_0003_0003_7FFF, 64'h0003_0003_0003_5000, 4'b0001);

    // Backpressure
    idle_cycles(2);
    out_ready = 1'b0;
    send(MODE_ADD, 64'h0010_0010_0010_0010, 64'h0001_0001_0001_0001, 1'b0, 1'b1,
         64'h0011_0011_0011_0011, 64'h0011_0011_0011_0011, 4'b0000);
    fork
      begin
        send(MODE_ADD, 64'h0020_0020_0020_0020, 64'h0002_0002_0002_0002, 1'b0, 1'b1,
             64'h0022_0022_0022_0022, 64'h0022_0022_0022_0022, 4'b0000);
        send(MODE_SUB, 64'h0036_0036_0036_0036, 64'h0003_0003_0003_0003, 1'b0, 1'b1,
             64'h0033_0033_0033_0033, 64'h0033_0033_0033_0033, 4'b0000);
        send(MODE_ADD, 64'h0040_0040_0040_0040, 64'h0004_0004_0004_0004, 1'b0, 1'b1,
             64'h0044_0044_0044_0044, 64'h0044_0044_0044_0044, 4'b0000);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", {63'd0, in_ready_s}, 64'd0);
          chk("stall_out_valid", {63'd0, out_valid_s}, 64'd1);
          chk("stall_out_vec", out_vec_s, 64'h0011_0011_0011_0011);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) begin
          @(negedge clk);
          chk("burst_out_valid", {63'd0, out_valid_s}, 64'd1);
        end
      end
    join

    // Reset mid-accumulation discards the partial sum
    idle_cycles(2);
    send(MODE_ACC, 64'h0100_0100_0100_0100, '0, 1'b0, 1'b0, '0, '0, '0);
    send(MODE_ACC, 64'h0100_0100_0100_0100, '0, 1'b0, 1'b0, '0, '0, '0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", {63'd0, out_valid_s}, 64'd0);
    chk("midrst_in_ready", {63'd0, in_ready_s}, 64'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle_cycles(1);
    send(MODE_ACC, 64'h0100_0100_0100_0100, '0, 1'b1, 1'b1,
         64'h0100_0100_0100_0100, 64'h0100_0100_0100_0100, 4'b0000);

    idle_cycles(4);
    chk("sat_queue_empty", 64'(q_s.size()), 64'd0);
    chk("wrap_queue_empty", 64'(q_w.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
